sap_regfile: RTL and testbench

Parametrised multi-register storage block for the SAP datapath. It holds NUM_REGS words of DATA_WIDTH bits and has one write/modify port and two combinational read ports. The write port can load, increment or decrement the addressed register, so one block serves as the general registers, the program counter and the memory address register. Registered zero and carry flags describe the most recent modify operation.

---
 rtl/sap_pkg.sv | 13 +
 rtl/sap_incdec.sv | 34 +++
 rtl/sap_regfile.sv | 101 ++++++++++
 tb/tb_sap_regfile.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP register file: write-port op encoding.
package sap_pkg;

    localparam int unsigned OP_WIDTH = 2;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_HOLD = 2'b00,
        OP_LOAD = 2'b01,
        OP_INC  = 2'b10,
        OP_DEC  = 2'b11
    } op_t;

endpackage : sap_pkg

// File: rtl/sap_incdec.sv
// Combinational modify unit: computes the new register value and its flags.
module sap_incdec
    import sap_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] old_val,
    input  op_t                   op,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] result_c,
    output logic                  carry_c,
    output logic                  zero_c
);

    // Result and carry per op; HOLD passes the old value through.
    always_comb begin
        result_c = old_val;
        carry_c  = 1'b0;
        case (op)
            OP_LOAD: result_c = wdata;
            OP_INC: begin
                result_c = old_val + DATA_WIDTH'(1);
                carry_c  = &old_val;
            end
            OP_DEC: begin
                result_c = old_val - DATA_WIDTH'(1);
                carry_c  = ~|old_val;
            end
            default: result_c = old_val;
        endcase
        zero_c = (result_c == '0);
    end

endmodule : sap_incdec

// File: rtl/sap_regfile.sv
// Multi-register store with one load/inc/dec write port, two combinational
// read ports with optional write-through bypass, and zero/carry flags.
module sap_regfile
    import sap_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned NUM_REGS   = 4,
    parameter  bit          BYPASS     = 1'b1,
    localparam int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  i_en,
    input  logic [1:0]            i_op,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr_a,
    input  logic [ADDR_WIDTH-1:0] i_raddr_b,
    output logic [DATA_WIDTH-1:0] o_rdata_a,
    output logic [DATA_WIDTH-1:0] o_rdata_b,
    output logic                  o_zero,
    output logic                  o_carry
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    op_t                   op_c;
    logic                  waddr_ok_c;
    logic                  raddr_a_ok_c;
    logic                  raddr_b_ok_c;
    logic                  we_c;
    logic [DATA_WIDTH-1:0] old_c;
    logic [DATA_WIDTH-1:0] result_c;
    logic                  carry_c;
    logic                  zero_c;

    assign op_c = op_t'(i_op);

    // Address range checks only matter when NUM_REGS leaves holes in the map.
    if (NUM_REGS == (1 << ADDR_WIDTH)) begin : g_full_map
        assign waddr_ok_c   = 1'b1;
        assign raddr_a_ok_c = 1'b1;
        assign raddr_b_ok_c = 1'b1;
    end else begin : g_partial_map
        assign waddr_ok_c   = 32'(i_waddr)   < NUM_REGS;
        assign raddr_a_ok_c = 32'(i_raddr_a) < NUM_REGS;
        assign raddr_b_ok_c = 32'(i_raddr_b) < NUM_REGS;
    end

    // Write-enable qualification and selection of the register being modified.
    always_comb begin
        we_c  = i_en && (op_c != OP_HOLD) && waddr_ok_c;
        old_c = '0;
        if (waddr_ok_c) begin
            old_c = regs[i_waddr];
        end
    end

    sap_incdec #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_incdec (
        .old_val  (old_c),
        .op       (op_c),
        .wdata    (i_wdata),
        .result_c (result_c),
        .carry_c  (carry_c),
        .zero_c   (zero_c)
    );

    // Register array and flags; clr wins over any write.
    always_ff @(posedge clk) begin
        if (clr) begin
            regs    <= '{default: '0};
            o_zero  <= 1'b0;
            o_carry <= 1'b0;
        end else if (we_c) begin
            regs[i_waddr] <= result_c;
            o_zero        <= zero_c;
            o_carry       <= carry_c;
        end
    end

    // Read muxes: holes read as 0, optional bypass of the in-flight result.
    always_comb begin
        o_rdata_a = '0;
        o_rdata_b = '0;
        if (raddr_a_ok_c) begin
            o_rdata_a = regs[i_raddr_a];
        end
        if (raddr_b_ok_c) begin
            o_rdata_b = regs[i_raddr_b];
        end
        if (BYPASS && we_c && (i_raddr_a == i_waddr)) begin
            o_rdata_a = result_c;
        end
        if (BYPASS && we_c && (i_raddr_b == i_waddr)) begin
            o_rdata_b = result_c;
        end
    end

endmodule : sap_regfile

// File: tb/tb_sap_regfile.sv
// Scoreboard bench for sap_regfile: three instances (bypass, no bypass,
// three-register map) share one stimulus stream.
module tb_sap_regfile;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] INC  = 2'b10;
    localparam logic [1:0] DEC  = 2'b11;

    // Signal selectors for the monitor.
    localparam int M_A = 0, M_B = 1, M_Z = 2, M_C = 3, N_A = 4, T_A = 5, T_Z = 6, T_C = 7;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       en = 1'b0;
    logic [1:0] op = HOLD;
    logic [1:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic [1:0] ra = '0;
    logic [1:0] rb = '0;

    logic [7:0] m_a, m_b, n_a, n_b, t_a, t_b;
    logic       m_z, m_c, n_z, n_c, t_z, t_c;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        int         sel;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sap_regfile #(.DATA_WIDTH(8), .NUM_REGS(4), .BYPASS(1'b1)) u_main (
        .clk(clk), .clr(clr), .i_en(en), .i_op(op), .i_waddr(waddr), .i_wdata(wdata),
        .i_raddr_a(ra), .i_raddr_b(rb), .o_rdata_a(m_a), .o_rdata_b(m_b),
        .o_zero(m_z), .o_carry(m_c)
    );

    sap_regfile #(.DATA_WIDTH(8), .NUM_REGS(4), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .clr(clr), .i_en(en), .i_op(op), .i_waddr(waddr), .i_wdata(wdata),
        .i_raddr_a(ra), .i_raddr_b(rb), .o_rdata_a(n_a), .o_rdata_b(n_b),
        .o_zero(n_z), .o_carry(n_c)
    );

    sap_regfile #(.DATA_WIDTH(8), .NUM_REGS(3), .BYPASS(1'b1)) u_three (
        .clk(clk), .clr(clr), .i_en(en), .i_op(op), .i_waddr(waddr), .i_wdata(wdata),
        .i_raddr_a(ra), .i_raddr_b(rb), .o_rdata_a(t_a), .o_rdata_b(t_b),
        .o_zero(t_z), .o_carry(t_c)
    );

    function automatic logic [7:0] observe(input int sel);
        case (sel)
            M_A: return m_a;
            M_B: return m_b;
            M_Z: return 8'(m_z);
            M_C: return 8'(m_c);
            N_A: return n_a;
            T_A: return t_a;
            T_Z: return 8'(t_z);
            T_C: return 8'(t_c);
            default: return 8'hxx;
        endcase
    endfunction

    // Monitor: on the falling edge compare every expectation due this cycle.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                logic [7:0] act;
                act = observe(q[i].sel);
                checks++;
                if (act !== q[i].exp) begin
                    failures++;
                    $display("FAIL %s cyc=%0d actual=%02h required=%02h",
                             q[i].name, cyc, act, q[i].exp);
                end
                q.delete(i);
            end
        end
    end

    task automatic drive(input logic c, input logic e, input logic [1:0] o,
                         input logic [1:0] w, input logic [7:0] d,
                         input logic [1:0] a, input logic [1:0] b);
        @(posedge clk);
        #1;
        clr = c; en = e; op = o; waddr = w; wdata = d; ra = a; rb = b;
    endtask

    task automatic expect_now(input int sel, input logic [7:0] v, input string nm);
        exp_t x;
        x.cyc = cyc; x.sel = sel; x.exp = v; x.name = nm;
        q.push_back(x);
    endtask

    initial begin
        drive(1, 0, HOLD, 0, 8'h00, 0, 0);
        drive(1, 0, HOLD, 0, 8'h00, 0, 0);

        // Populate with nonzero data and set carry before reset.
        drive(0, 1, LOAD, 1, 8'h22, 1, 1);
        drive(0, 1, LOAD, 2, 8'h33, 2, 2);
        drive(0, 1, LOAD, 3, 8'h44, 3, 3);
        drive(0, 1, DEC,  0, 8'h00, 0, 0);
        drive(0, 0, HOLD, 0, 8'h00, 0, 3);
        expect_now(M_A, 8'hFF, "pre_clr_r0");
        expect_now(M_B, 8'h44, "pre_clr_r3");
        expect_now(M_C, 8'h01, "pre_clr_carry");
        expect_now(T_C, 8'h01, "pre_clr_carry_t");

        // clr with an active INC: everything clears, INC discarded.
        drive(1, 1, INC,  0, 8'h00, 0, 1);
        drive(0, 0, INC,  0, 8'h00, 0, 1);
        expect_now(M_A, 8'h00, "clr_r0");
        expect_now(M_B, 8'h00, "clr_r1");
        expect_now(M_Z, 8'h00, "clr_zero");
        expect_now(M_C, 8'h00, "clr_carry");
        expect_now(T_C, 8'h00, "clr_carry_t");
        expect_now(N_A, 8'h00, "clr_r0_nobyp");
        drive(0, 0, HOLD, 0, 8'h00, 2, 3);
        expect_now(M_A, 8'h00, "clr_r2");
        expect_now(M_B, 8'h00, "clr_r3");

        // LOAD 0xFE then INC twice to wrap.
        drive(0, 1, LOAD, 2, 8'hFE, 2, 2);
        expect_now(M_A, 8'hFE, "load_fe_bypass");
        expect_now(N_A, 8'h00, "load_fe_nobyp");
        drive(0, 1, INC,  2, 8'h00, 2, 2);
        expect_now(M_A, 8'hFF, "inc1_bypass");
        expect_now(N_A, 8'hFE, "inc1_nobyp");
        expect_now(M_C, 8'h00, "load_carry");
        drive(0, 1, INC,  2, 8'h00, 2, 2);
        expect_now(M_A, 8'h00, "inc2_bypass");
        expect_now(N_A, 8'hFF, "inc2_nobyp");
        expect_now(M_Z, 8'h00, "inc1_zero");
        expect_now(M_C, 8'h00, "inc1_carry");
        drive(0, 0, HOLD, 0, 8'h00, 2, 2);
        expect_now(M_A, 8'h00, "wrap_r2");
        expect_now(M_Z, 8'h01, "wrap_zero");
        expect_now(M_C, 8'h01, "wrap_carry");
        expect_now(T_Z, 8'h01, "wrap_zero_t");
        expect_now(T_C, 8'h01, "wrap_carry_t");

        // DEC borrow from zero, then LOAD clears carry.
        drive(0, 1, DEC,  1, 8'h00, 1, 1);
        expect_now(M_A, 8'hFF, "dec_bypass");
        expect_now(N_A, 8'h00, "dec_nobyp");
        drive(0, 1, LOAD, 1, 8'h05, 1, 1);
        expect_now(M_Z, 8'h00, "dec_zero");
        expect_now(M_C, 8'h01, "dec_carry");
        expect_now(M_A, 8'h05, "load5_bypass_a");
        expect_now(M_B, 8'h05, "load5_bypass_b");
        expect_now(N_A, 8'hFF, "load5_nobyp");
        drive(0, 0, HOLD, 0, 8'h00, 1, 1);
        expect_now(M_C, 8'h00, "load5_carry");
        expect_now(M_Z, 8'h00, "load5_zero");
        expect_now(M_A, 8'h05, "r1_a");
        expect_now(M_B, 8'h05, "r1_b");

        // Set carry again so the out-of-range write can be seen leaving it alone.
        drive(0, 1, DEC,  0, 8'h00, 0, 0);
        expect_now(M_A, 8'hFF, "dec_r0_bypass");

        // LOAD r3 = 0x5A: bypass vs stored value, and a hole in the three-reg map.
        drive(0, 1, LOAD, 3, 8'h5A, 3, 3);
        expect_now(M_A, 8'h5A, "load5a_bypass");
        expect_now(N_A, 8'h00, "load5a_nobyp");
        expect_now(T_A, 8'h00, "oor_read_during_write");
        expect_now(M_C, 8'h01, "dec_r0_carry");
        drive(0, 0, HOLD, 0, 8'h00, 3, 3);
        expect_now(M_A, 8'h5A, "r3_stored");
        expect_now(N_A, 8'h5A, "r3_stored_nobyp");
        expect_now(T_A, 8'h00, "oor_read");
        expect_now(M_C, 8'h00, "load5a_carry");
        expect_now(T_C, 8'h01, "oor_carry_kept");
        expect_now(T_Z, 8'h00, "oor_zero_kept");

        // Idle cycles: disabled INC, then enabled HOLD.
        drive(0, 0, INC,  0, 8'h00, 0, 0);
        expect_now(M_A, 8'hFF, "en0_inc_a");
        expect_now(M_B, 8'hFF, "en0_inc_b");
        drive(0, 1, HOLD, 0, 8'h00, 0, 0);
        expect_now(M_A, 8'hFF, "hold_a");
        expect_now(M_B, 8'hFF, "hold_b");
        expect_now(M_Z, 8'h00, "en0_zero");
        expect_now(M_C, 8'h00, "en0_carry");
        drive(0, 0, HOLD, 0, 8'h00, 0, 0);
        expect_now(M_A, 8'hFF, "idle_r0");
        expect_now(M_Z, 8'h00, "hold_zero");
        expect_now(M_C, 8'h00, "hold_carry");
        expect_now(T_C, 8'h01, "idle_carry_t");

        drive(0, 0, HOLD, 0, 8'h00, 0, 0);
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            failures += q.size();
            $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sap_regfile
